// File: rtl/id_redirect_stage.sv
// rtl/id_redirect_stage.sv - IF/ID pipeline register with early branch/jump resolution and hazard stall
//
// Holds the instruction and pc_plus4 handed over by fetch. Decodes it early
// enough to resolve branches and jumps in ID, so fetch can be redirected.
// Also detects load-use and branch-operand hazards, which stall fetch and
// insert a bubble.
//
// Optional feature macro: PERF_CNT_EN. When it is defined, saturating
// stall/flush counters are built. When it is undefined, both counter
// outputs are tied to zero.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   if_instr          instruction from fetch
//   if_pc_plus4       pc_plus4 from fetch
//   rs_data, rt_data  register-file read data for id_rs / id_rt
//   ex_rd             destination register of the EX instruction
//   ex_reg_write      EX instruction writes a register
//   ex_mem_read       EX instruction is a load
//   mem_rd            destination register of the MEM instruction
//   mem_mem_read      MEM instruction is a load
//   if_en             fetch PC enable (0 = stall)
//   branch_taken      redirect fetch to branch_address
//   branch_address    branch target
//   jump              redirect fetch to jump_address
//   jump_address      jump target
//   id_instr          registered instruction
//   id_pc_plus4       registered pc_plus4
//   id_valid          id_instr is a real instruction
//   id_rs, id_rt      register-file read addresses
//   id_bubble         insert a NOP into ID/EX this cycle
//   stall_count       stall cycles seen
//   flush_count       flushes seen
module id_redirect_stage #(
    parameter int          PC_WIDTH  = 10,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         if_instr,
    input  logic [PC_WIDTH-1:0] if_pc_plus4,
    input  logic [31:0]         rs_data,
    input  logic [31:0]         rt_data,
    input  logic [4:0]          ex_rd,
    input  logic                ex_reg_write,
    input  logic                ex_mem_read,
    input  logic [4:0]          mem_rd,
    input  logic                mem_mem_read,
    output logic                if_en,
    output logic                branch_taken,
    output logic [PC_WIDTH-1:0] branch_address,
    output logic                jump,
    output logic [PC_WIDTH-1:0] jump_address,
    output logic [31:0]         id_instr,
    output logic [PC_WIDTH-1:0] id_pc_plus4,
    output logic                id_valid,
    output logic [4:0]          id_rs,
    output logic [4:0]          id_rt,
    output logic                id_bubble,
    output logic [15:0]         stall_count,
    output logic [15:0]         flush_count
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [31:0]         instr_q;
    logic [31:0]         instr_d;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic                valid_q;
    logic                valid_d;

    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm16;
    logic        is_beq;
    logic        is_bne;
    logic        is_branch;
    logic        is_jump;
    logic        uses_rt;
    logic        load_use;
    logic        br_ex;
    logic        br_mem;
    logic        stall;
    logic        br_cond;
    logic        redirect;

    assign op    = instr_q[31:26];
    assign rs    = instr_q[25:21];
    assign rt    = instr_q[20:16];
    assign imm16 = instr_q[15:0];

    assign is_beq    = (op == OP_BEQ);
    assign is_bne    = (op == OP_BNE);
    assign is_branch = is_beq | is_bne;
    assign is_jump   = (op == OP_J) | (op == OP_JAL);
    assign uses_rt   = (op == OP_RTYPE) | is_branch | (op == OP_SW);

    // In J/JAL the rs/rt fields are target bits, not register numbers, so
    // load-use matching is suppressed for jumps; jumps never stall.
    assign load_use = ex_mem_read & (ex_rd != 5'd0) & ~is_jump &
                      ((ex_rd == rs) | (uses_rt & (ex_rd == rt)));

    // Branches compare in ID, so any producer still in EX is too late. A load
    // still in MEM is also too late, which yields two stall cycles for a
    // load feeding a branch.
    assign br_ex  = is_branch & ex_reg_write & (ex_rd != 5'd0) &
                    ((ex_rd == rs) | (ex_rd == rt));
    assign br_mem = is_branch & mem_mem_read & (mem_rd != 5'd0) &
                    ((mem_rd == rs) | (mem_rd == rt));

    assign stall = valid_q & (load_use | br_ex | br_mem);

    assign br_cond = is_beq ? (rs_data == rt_data) : (rs_data != rt_data);

    assign if_en        = ~stall;
    assign id_bubble    = stall;
    assign branch_taken = valid_q & ~stall & is_branch & br_cond;
    assign jump         = valid_q & ~stall & is_jump;
    assign redirect     = branch_taken | jump;

    // Target arithmetic wraps modulo 2**PC_WIDTH.
    assign branch_address = pc_q + PC_WIDTH'({{14{imm16[15]}}, imm16, 2'b00});
    assign jump_address   = {instr_q[PC_WIDTH-3:0], 2'b00};

    assign id_instr    = instr_q;
    assign id_pc_plus4 = pc_q;
    assign id_valid    = valid_q;
    assign id_rs       = rs;
    assign id_rt       = rt;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (stall) begin
            instr_d = instr_q;
        end else if (redirect) begin
            // Squash the wrong-path fetch; fetch loads the target on this edge.
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else begin
            instr_d = if_instr;
            pc_d    = if_pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

`ifdef PERF_CNT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            if (stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'h0001;
            end
            if (redirect && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'h0001;
            end
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = 16'h0000;
    assign flush_count = 16'h0000;
`endif

endmodule

// File: tb/tb_id_redirect_stage.sv
// tb/tb_id_redirect_stage.sv - directed self-checking bench for id_redirect_stage
module tb_id_redirect_stage;

    localparam int PW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   if_instr;
    logic [PW-1:0] if_pc_plus4;
    logic [31:0]   rs_data;
    logic [31:0]   rt_data;
    logic [4:0]    ex_rd;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic [4:0]    mem_rd;
    logic          mem_mem_read;
    logic          if_en;
    logic          branch_taken;
    logic [PW-1:0] branch_address;
    logic          jump;
    logic [PW-1:0] jump_address;
    logic [31:0]   id_instr;
    logic [PW-1:0] id_pc_plus4;
    logic          id_valid;
    logic [4:0]    id_rs;
    logic [4:0]    id_rt;
    logic          id_bubble;
    logic [15:0]   stall_count;
    logic [15:0]   flush_count;

    int errors = 0;
    int checks = 0;

`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    id_redirect_stage #(.PC_WIDTH(PW), .NOP_INSTR(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .if_instr(if_instr), .if_pc_plus4(if_pc_plus4),
        .rs_data(rs_data), .rt_data(rt_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_mem_read(mem_mem_read),
        .if_en(if_en), .branch_taken(branch_taken), .branch_address(branch_address),
        .jump(jump), .jump_address(jump_address), .id_instr(id_instr),
        .id_pc_plus4(id_pc_plus4), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_bubble(id_bubble), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then leave time for outputs to settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] perf(input logic [15:0] v);
        return PERF ? v : 16'h0000;
    endfunction

    initial begin
        reset = 1'b0; if_instr = 32'h8C01_0004; if_pc_plus4 = '0;
        rs_data = 0; rt_data = 0; ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
        mem_rd = 0; mem_mem_read = 0;

        // Reset
        step(); step();
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_if_en", 32'(if_en), 32'd1);
        chk("rst_br", 32'(branch_taken), 32'd0);
        chk("rst_jump", 32'(jump), 32'd0);
        chk("rst_bubble", 32'(id_bubble), 32'd0);
        chk("rst_sc", 32'(stall_count), 32'd0);
        chk("rst_fc", 32'(flush_count), 32'd0);

        // Straight-line load
        reset = 1'b1; if_instr = 32'h0022_1820; if_pc_plus4 = 10'h004;
        step();
        chk("sl_instr", id_instr, 32'h0022_1820);
        chk("sl_pc", 32'(id_pc_plus4), 32'h004);
        chk("sl_valid", 32'(id_valid), 32'd1);
        chk("sl_if_en", 32'(if_en), 32'd1);
        chk("sl_rs", 32'(id_rs), 32'd1);
        chk("sl_rt", 32'(id_rt), 32'd2);

        // Load-use on rt: one stall cycle
        if_instr = 32'h1022_0003; if_pc_plus4 = 10'h010;
        ex_mem_read = 1; ex_rd = 5'd2; #1;
        chk("lu_if_en", 32'(if_en), 32'd0);
        chk("lu_bubble", 32'(id_bubble), 32'd1);
        step();
        chk("lu_hold", id_instr, 32'h0022_1820);
        chk("lu_hold_pc", 32'(id_pc_plus4), 32'h004);
        ex_mem_read = 0; ex_rd = 0; #1;
        chk("lu_release", 32'(if_en), 32'd1);
        chk("lu_sc", 32'(stall_count), 32'(perf(16'd1)));

        // BEQ taken
        step();
        chk("beq_instr", id_instr, 32'h1022_0003);
        rs_data = 32'd5; rt_data = 32'd6; #1;
        chk("beq_nt", 32'(branch_taken), 32'd0);
        rt_data = 32'd5; #1;
        chk("beq_taken", 32'(branch_taken), 32'd1);
        chk("beq_addr", 32'(branch_address), 32'h01C);
        chk("beq_jump", 32'(jump), 32'd0);
        chk("beq_if_en", 32'(if_en), 32'd1);
        if_instr = 32'h0043_2020; if_pc_plus4 = 10'h014;
        step();
        chk("beq_flush_v", 32'(id_valid), 32'd0);
        chk("beq_flush_i", id_instr, 32'h0);
        chk("beq_flush_br", 32'(branch_taken), 32'd0);
        chk("beq_fc", 32'(flush_count), 32'(perf(16'd1)));

        // BNE with load in EX on rs: two stall cycles, negative offset wraps
        if_instr = 32'h1423_FFFE; if_pc_plus4 = 10'h004;
        step();
        chk("bne_instr", id_instr, 32'h1423_FFFE);
        rs_data = 32'd7; rt_data = 32'd8;
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd1; #1;
        chk("bne_st1_en", 32'(if_en), 32'd0);
        chk("bne_st1_bub", 32'(id_bubble), 32'd1);
        chk("bne_st1_br", 32'(branch_taken), 32'd0);
        step();
        ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0;
        mem_mem_read = 1; mem_rd = 5'd1; #1;
        chk("bne_st2_en", 32'(if_en), 32'd0);
        chk("bne_st2_br", 32'(branch_taken), 32'd0);
        chk("bne_st2_hold", id_instr, 32'h1423_FFFE);
        step();
        mem_mem_read = 0; mem_rd = 0; #1;
        chk("bne_go_en", 32'(if_en), 32'd1);
        chk("bne_taken", 32'(branch_taken), 32'd1);
        chk("bne_addr", 32'(branch_address), 32'h3FC);
        chk("bne_sc", 32'(stall_count), 32'(perf(16'd3)));
        if_instr = 32'h0000_0000; if_pc_plus4 = 10'h008;
        step();
        chk("bne_flush_v", 32'(id_valid), 32'd0);
        chk("bne_fc", 32'(flush_count), 32'(perf(16'd2)));

        // Jump
        if_instr = 32'h0800_0040; if_pc_plus4 = 10'h3FC;
        step();
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd1; #1;
        chk("j_jump", 32'(jump), 32'd1);
        chk("j_addr", 32'(jump_address), 32'h100);
        chk("j_if_en", 32'(if_en), 32'd1);
        chk("j_br", 32'(branch_taken), 32'd0);
        if_instr = 32'h0043_2020; if_pc_plus4 = 10'h000;
        step();
        chk("j_flush_v", 32'(id_valid), 32'd0);
        chk("j_flush_i", id_instr, 32'h0);
        chk("j_flush_jump", 32'(jump), 32'd0);
        chk("j_fc", 32'(flush_count), 32'(perf(16'd3)));

        // JAL whose field bits equal ex_rd: still no stall
        if_instr = 32'h0C21_0040; if_pc_plus4 = 10'h104;
        step();
        chk("jal_rs", 32'(id_rs), 32'd1);
        chk("jal_if_en", 32'(if_en), 32'd1);
        chk("jal_jump", 32'(jump), 32'd1);
        chk("jal_addr", 32'(jump_address), 32'h100);

        // Reset mid-stall
        ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0;
        if_instr = 32'h0022_1820; if_pc_plus4 = 10'h100;
        step();
        step();
        ex_mem_read = 1; ex_rd = 5'd1; #1;
        chk("rms_stall", 32'(if_en), 32'd0);
        reset = 1'b0;
        step();
        chk("rms_valid", 32'(id_valid), 32'd0);
        chk("rms_if_en", 32'(if_en), 32'd1);
        chk("rms_bubble", 32'(id_bubble), 32'd0);
        chk("rms_sc", 32'(stall_count), 32'd0);
        chk("rms_fc", 32'(flush_count), 32'd0);

        // Register 0 never hazards
        reset = 1'b1; ex_rd = 5'd0; ex_reg_write = 1;
        if_instr = 32'h0000_1820; if_pc_plus4 = 10'h004;
        step();
        chk("r0_valid", 32'(id_valid), 32'd1);
        chk("r0_if_en", 32'(if_en), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_redirect_stage.md
Name: id_redirect_stage

Overview:
- Consumer end of the fetch interface: the IF/ID pipeline register plus early branch/jump resolution in decode.
- Latches `instr`/`pc_plus4` from fetch.
- Drives fetch's `en` (stall) and the redirect controls `branch_taken`, `jump`, `branch_address` and `jump_address`.
- Flushes the wrong-path instruction and detects load-use and branch-operand hazards.

Parameters:
- PC_WIDTH, 10, width of PC and target addresses.
- NOP_INSTR, 32'h0000_0000, value loaded into the IF/ID register on reset or flush.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 clears state on the next rising clk).
- if_instr  in  32  instruction from fetch.
- if_pc_plus4  in  PC_WIDTH  pc_plus4 from fetch.
- rs_data  in  32  register-file read data for id_rs.
- rt_data  in  32  register-file read data for id_rt.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_reg_write  in  1  EX instruction writes a register.
- ex_mem_read  in  1  EX instruction is a load.
- mem_rd  in  5  destination register of the instruction in MEM.
- mem_mem_read  in  1  MEM instruction is a load.
- if_en  out  1  fetch PC enable; 0 = stall.
- branch_taken  out  1  redirect fetch to branch_address.
- branch_address  out  PC_WIDTH  branch target.
- jump  out  1  redirect fetch to jump_address.
- jump_address  out  PC_WIDTH  jump target.
- id_instr  out  32  registered instruction.
- id_pc_plus4  out  PC_WIDTH  registered pc_plus4.
- id_valid  out  1  id_instr is a real instruction.
- id_rs  out  5  id_instr[25:21], register-file read address.
- id_rt  out  5  id_instr[20:16], register-file read address.
- id_bubble  out  1  insert a NOP into ID/EX this cycle.
- stall_count  out  16  stall cycles seen (optional feature).
- flush_count  out  16  flushes seen (optional feature).

Behaviour:
- Reset (reset==0 at clk edge):
  - id_instr=NOP_INSTR, id_pc_plus4=0, id_valid=0, counters=0.
  - Consequently if_en=1, branch_taken=0, jump=0, id_bubble=0.
- Decode of id_instr (op=id_instr[31:26]):
  - BEQ=6'h04, BNE=6'h05, J=6'h02, JAL=6'h03, LW=6'h23, SW=6'h2B, R-type=6'h00.
  - uses_rt = R-type | BEQ | BNE | SW.
  - is_branch = BEQ | BNE.
- Hazard term (combinational, all terms qualified by id_valid):
  - stall = load-use OR branch-operand hazard, where:
  - load-use: ex_mem_read & ex_rd!=0 & (ex_rd==id_rs | (uses_rt & ex_rd==id_rt)).
  - branch-operand, EX: is_branch & ex_reg_write & ex_rd!=0 & (ex_rd==id_rs | ex_rd==id_rt).
  - branch-operand, MEM: is_branch & mem_mem_read & mem_rd!=0 & (mem_rd==id_rs | mem_rd==id_rt).
  - A load feeding a branch therefore stalls exactly 2 cycles; an ALU result feeding a branch stalls 1.
- Stall outputs: if_en = ~stall; id_bubble = stall.
- Redirect (combinational, forced 0 while stall):
  - branch_taken = is_branch & (BEQ ? rs_data==rt_data : rs_data!=rt_data).
  - branch_address = id_pc_plus4 + (sign-extended imm16 << 2), truncated to PC_WIDTH; wrap-around is permitted.
  - jump = J | JAL.
  - jump_address = {id_instr[PC_WIDTH-3:0], 2'b00}.
  - Both are asserted only when id_valid.
- IF/ID register update, priority reset > stall > redirect > load:
  - stall: hold id_instr, id_pc_plus4 and id_valid.
  - branch_taken|jump: load NOP_INSTR, id_valid=0. This flushes the wrong-path fetch; fetch loads the target on the same edge.
  - else: load if_instr/if_pc_plus4, id_valid=1.
- Latency:
  - Instruction visible on id_instr 1 cycle after fetch presents it.
  - Branch/jump penalty is exactly 1 bubble cycle.
- Boundaries:
  - Register 0 never causes a hazard.
  - Jumps never stall.
  - Back-to-back redirect is impossible: a flushed slot has id_valid=0.
  - Reset mid-stall clears all state immediately; there is no residual stall.

Optional Feature:
- Macro: PERF_CNT_EN.
- Defined:
  - stall_count increments on every cycle with stall=1.
  - flush_count increments on every cycle with branch_taken|jump=1.
  - Both are 16-bit and saturate at 16'hFFFF; reset to 0.
- Undefined: both outputs are tied to 16'h0000 and no counter flops are built.

Test Plan:
- Reset: hold reset=0 for 2 cycles with if_instr=32'h8C01_0004 -> id_valid=0, id_instr=0, if_en=1, branch_taken=0, jump=0.
- Straight-line: feed 32'h0022_1820 at if_pc_plus4=10'h004 -> next cycle id_instr=32'h0022_1820, id_pc_plus4=10'h004, id_valid=1, if_en=1.
- Load-use: id_instr=32'h0022_1820 (rs=1, rt=2), ex_mem_read=1, ex_rd=2 -> if_en=0 and id_bubble=1 for 1 cycle; id_instr held; counter +1 with PERF_CNT_EN.
- BEQ taken: id_instr=32'h1022_0003, id_pc_plus4=10'h010, rs_data=rt_data=5 -> branch_taken=1, branch_address=10'h01C; next cycle id_valid=0, id_instr=0.
- BNE with load in EX on rs: ex_mem_read=1, ex_rd=1 -> 2 stall cycles, then branch_taken evaluated; branch with negative imm16 16'hFFFE at id_pc_plus4=10'h004 -> branch_address=10'h3FC (wrap).
- Jump: id_instr=32'h0800_0040 -> jump=1, jump_address=10'h100, no stall even when ex_rd matches bits; next cycle flushed; flush_count +1 with PERF_CNT_EN.
